int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Interrupt controller sitting directly downstream of the timer and other peripherals. It consumes their level interrupt lines, including the timer's int_sig_o.
- Per-source gateway: latches pending, applies the enable mask, picks the lowest-index candidate, and presents a stable request/ID to the core with an ack handshake.
- The core signals end of service by writing the source ID to the COMPLETE register over the peripheral bus.

Parameters:
- NUM_SRC, 8: number of interrupt sources, 1..32.
- ID_W, 5: width of the source ID; must satisfy 2^ID_W >= NUM_SRC.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- int_src_i  in  NUM_SRC  level interrupt lines from peripherals; bit i = source i.
- data_i  in  32  bus write data.
- addr_i  in  32  bus address; only [3:0] decoded.
- we_i  in  1  bus write enable.
- data_o  out  32  bus read data, combinational.
- int_ack_i  in  1  core accepts the presented interrupt (1-cycle pulse).
- int_req_o  out  1  interrupt request to core.
- int_id_o  out  ID_W  ID of the requested source; valid while int_req_o=1.

Behaviour:
- Registers (offset addr_i[3:0]):
  - 0x0 ENABLE: RW, bits [NUM_SRC-1:0]; upper bits read 0.
  - 0x4 PENDING: RO.
  - 0x8 INFLIGHT: RO.
  - 0xC COMPLETE: WO. Write data[ID_W-1:0]=id clears inflight[id]; reads 0.
  - Other offsets read 0; writes to RO/unmapped offsets are ignored.
- data_o is combinational from addr_i and is 0 while rst=1.
- Reset (synchronous, rst=1 at posedge): ENABLE, PENDING, INFLIGHT and id_q all go to 0; FSM goes to IDLE; int_req_o=0; int_id_o=0. Reset asserted in any state, including REQ, aborts everything the next cycle.
- Gateway, per source i, registered:
  - pending[i] sets when int_src_i[i]=1 && pending[i]=0 && inflight[i]=0.
  - pending[i] clears only on ack of id i.
  - Sampling is level-based: a source still high after COMPLETE re-pends one cycle later.
  - Sources high while disabled still pend; they are requested once enabled.
- Candidate vector = pending & ENABLE. Selection is fixed priority, lowest index wins.
- FSM states IDLE and REQ:
  - IDLE: if the candidate vector is nonzero, latch id_q <= lowest set index and go to REQ next cycle.
  - REQ: int_req_o=1 and int_id_o=id_q, both registered and held stable. A higher-priority arrival does not change id_q.
  - REQ + int_ack_i=1: next cycle pending[id_q]=0, inflight[id_q]=1, state goes to IDLE.
  - REQ + ENABLE[id_q] cleared by a bus write: request is withdrawn and state goes to IDLE next cycle; pending stays set.
  - int_ack_i in IDLE is ignored.
- Latency: int_src_i rises at edge n, pending is set after edge n+1, int_req_o=1 after edge n+2.
- After an ack there is at least one IDLE cycle before the next request.
- Simultaneous events:
  - Ack and a new rising source for the same id: ack wins and the source is blocked by inflight.
  - COMPLETE and the source high in the same cycle: inflight clears; pending sets the following cycle, because the gateway uses the registered inflight value.
  - COMPLETE with id >= NUM_SRC, or for a source not inflight: no effect.
  - ENABLE write in the same cycle as an IDLE selection: the selection uses the old ENABLE; the withdraw rule applies the next cycle.

Test Plan:
1. Reset, write ENABLE=0x01, raise src[0] at cycle 0 -> int_req_o=1 at cycle 2 with int_id_o=0; ack -> next cycle int_req_o=0, PENDING=0x00, INFLIGHT=0x01.
2. With ENABLE=0xFF, src[5] and src[2] raised together -> int_id_o=2 first. After ack, id 5 is requested after 1 IDLE cycle. Raising src[1] while id 5 is in REQ leaves int_id_o=5.
3. Source held high through service, write COMPLETE=0 -> INFLIGHT[0]=0, PENDING[0]=1 one cycle later, request re-asserted. Dropping the source before COMPLETE -> no re-request.
4. src[3] high with ENABLE=0 -> PENDING=0x08, int_req_o=0. Write ENABLE=0x08 -> request for id 3 two cycles later. Clearing ENABLE while in REQ -> int_req_o=0 next cycle, PENDING still 0x08.
5. Edge cases: COMPLETE=9 (>= NUM_SRC) -> no state change; ack in IDLE -> ignored; read 0xC or 0x7 -> 0.
6. rst=1 while in REQ with INFLIGHT=0x04 -> next cycle all registers 0, int_req_o=0, and data_o=0 during reset.

Source files
------------

// File: rtl/int_ctrl.sv
// Interrupt controller: per-source pending/inflight gateway, enable mask,
// fixed-priority (lowest index) selection and a req/ack handshake to the core.
module int_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] int_src_i,
  input  logic [31:0]        data_i,
  input  logic [31:0]        addr_i,
  input  logic               we_i,
  output logic [31:0]        data_o,
  input  logic               int_ack_i,
  output logic               int_req_o,
  output logic [ID_W-1:0]    int_id_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  localparam logic [3:0] OFF_ENABLE   = 4'h0;
  localparam logic [3:0] OFF_PENDING  = 4'h4;
  localparam logic [3:0] OFF_INFLIGHT = 4'h8;
  localparam logic [3:0] OFF_COMPLETE = 4'hC;

  logic [0:0]         state_q;
  logic [NUM_SRC-1:0] enable_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] inflight_q;
  logic [ID_W-1:0]    id_q;

  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] pending_n;
  logic [NUM_SRC-1:0] inflight_n;
  logic [ID_W-1:0]    sel_id;
  logic [ID_W-1:0]    cmp_id;
  logic               id_enabled;
  logic               wr_enable;
  logic               wr_complete;
  logic               ack_fire;
  logic [31:0]        rd_data;
  logic               unused_bits;

  assign unused_bits = ^{addr_i[31:4], data_i};

  assign wr_enable   = we_i && (addr_i[3:0] == OFF_ENABLE);
  assign wr_complete = we_i && (addr_i[3:0] == OFF_COMPLETE);
  assign cmp_id      = data_i[ID_W-1:0];
  assign cand        = pending_q & enable_q;

  // Handshake: int_req_o/int_id_o are held stable while in REQ; the core
  // pulses int_ack_i for one cycle to take the request. Ack outside REQ is ignored.
  assign ack_fire  = (state_q == ST_REQ) && int_ack_i;
  assign int_req_o = (state_q == ST_REQ);
  assign int_id_o  = id_q;

  // Descending scan so the lowest set index is the last (winning) assignment.
  always_comb begin
    sel_id     = '0;
    id_enabled = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) sel_id = ID_W'(i);
      if (id_q == ID_W'(i)) id_enabled = enable_q[i];
    end
  end

  // Gateway uses the registered inflight, so a COMPLETE re-pends a held source one cycle later.
  always_comb begin
    pending_n  = pending_q | (int_src_i & ~inflight_q);
    inflight_n = inflight_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (wr_complete && (cmp_id == ID_W'(i))) inflight_n[i] = 1'b0;
      if (ack_fire && (id_q == ID_W'(i))) begin
        pending_n[i]  = 1'b0;
        inflight_n[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      enable_q   <= '0;
      pending_q  <= '0;
      inflight_q <= '0;
      id_q       <= '0;
    end else begin
      if (wr_enable) enable_q <= data_i[NUM_SRC-1:0];
      pending_q  <= pending_n;
      inflight_q <= inflight_n;
      case (state_q)
        ST_IDLE: begin
          if (|cand) begin
            id_q    <= sel_id;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (int_ack_i || !id_enabled) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr_i[3:0])
      OFF_ENABLE:   rd_data[NUM_SRC-1:0] = enable_q;
      OFF_PENDING:  rd_data[NUM_SRC-1:0] = pending_q;
      OFF_INFLIGHT: rd_data[NUM_SRC-1:0] = inflight_q;
      default:      rd_data = '0;
    endcase
    data_o = rst ? 32'h0 : rd_data;
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: bus register access, gateway latency, priority,
// re-pend after COMPLETE, enable withdraw, edge cases and reset abort.
module tb_int_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  int_src_i;
  logic [31:0] data_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [31:0] data_o;
  logic        int_ack_i;
  logic        int_req_o;
  logic [4:0]  int_id_o;

  int checks;
  int failures;

  int_ctrl #(.NUM_SRC(8), .ID_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .int_src_i (int_src_i),
    .data_i    (data_i),
    .addr_i    (addr_i),
    .we_i      (we_i),
    .data_o    (data_o),
    .int_ack_i (int_ack_i),
    .int_req_o (int_req_o),
    .int_id_o  (int_id_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    addr_i = addr;
    data_i = data;
    we_i   = 1'b1;
    tick();
    we_i   = 1'b0;
    data_i = '0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    addr_i = addr;
    #1;
    check(tag, data_o, exp);
  endtask

  task automatic ack_pulse();
    int_ack_i = 1'b1;
    tick();
    int_ack_i = 1'b0;
  endtask

  task automatic check_req(input string tag, input logic req, input logic [4:0] id);
    check({tag, "_req"}, {31'b0, int_req_o}, {31'b0, req});
    if (req) check({tag, "_id"}, {27'b0, int_id_o}, {27'b0, id});
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    int_src_i = '0;
    data_i    = '0;
    addr_i    = 32'h4;
    we_i      = 1'b0;
    int_ack_i = 1'b0;
    tick();
    tick();
    check("rst_data_o", data_o, 32'h0);
    rst = 1'b0;
    check("rst_req", {31'b0, int_req_o}, 32'h0);
    check("rst_id", {27'b0, int_id_o}, 32'h0);
    read_check("rst_enable", 32'h0, 32'h0);
    read_check("rst_pending", 32'h4, 32'h0);
    read_check("rst_inflight", 32'h8, 32'h0);

    // 1: single source, two-cycle latency, ack moves pending -> inflight
    bus_write(32'h0, 32'h01);
    int_src_i = 8'h01;
    tick();
    check_req("t1_c1", 1'b0, 5'd0);
    read_check("t1_pend_c1", 32'h4, 32'h01);
    tick();
    check_req("t1_c2", 1'b1, 5'd0);
    ack_pulse();
    check_req("t1_after_ack", 1'b0, 5'd0);
    read_check("t1_pending", 32'h4, 32'h00);
    read_check("t1_inflight", 32'h8, 32'h01);

    // 3: held source re-pends one cycle after COMPLETE
    tick();
    read_check("t3_blocked", 32'h4, 32'h00);
    bus_write(32'hC, 32'h0);
    read_check("t3_infl_clr", 32'h8, 32'h00);
    read_check("t3_pend_not_yet", 32'h4, 32'h00);
    tick();
    read_check("t3_repend", 32'h4, 32'h01);
    check_req("t3_repend", 1'b0, 5'd0);
    tick();
    check_req("t3_rereq", 1'b1, 5'd0);
    ack_pulse();
    int_src_i = 8'h00;
    bus_write(32'hC, 32'h0);
    tick();
    tick();
    read_check("t3_no_repend", 32'h4, 32'h00);
    check_req("t3_no_rereq", 1'b0, 5'd0);

    // 2: priority, IDLE gap after ack, no preemption in REQ
    bus_write(32'h0, 32'hFF);
    int_src_i = 8'h24;
    tick();
    tick();
    check_req("t2_first", 1'b1, 5'd2);
    ack_pulse();
    check_req("t2_idle_gap", 1'b0, 5'd0);
    read_check("t2_pending", 32'h4, 32'h20);
    read_check("t2_inflight", 32'h8, 32'h04);
    tick();
    check_req("t2_second", 1'b1, 5'd5);
    int_src_i = 8'h26;
    tick();
    tick();
    check_req("t2_hold", 1'b1, 5'd5);
    read_check("t2_pend_hold", 32'h4, 32'h22);
    ack_pulse();
    tick();
    check_req("t2_third", 1'b1, 5'd1);
    ack_pulse();
    int_src_i = 8'h00;
    bus_write(32'hC, 32'h5);
    bus_write(32'hC, 32'h2);
    bus_write(32'hC, 32'h1);
    read_check("t2_infl_clean", 32'h8, 32'h00);
    read_check("t2_pend_clean", 32'h4, 32'h00);

    // 4: disabled source still pends; enable later; withdraw keeps pending
    bus_write(32'h0, 32'h00);
    int_src_i = 8'h08;
    tick();
    tick();
    read_check("t4_pending", 32'h4, 32'h08);
    check_req("t4_masked", 1'b0, 5'd0);
    int_src_i = 8'h00;
    bus_write(32'h0, 32'h08);
    tick();
    check_req("t4_enabled", 1'b1, 5'd3);
    bus_write(32'h0, 32'h00);
    tick();
    check_req("t4_withdrawn", 1'b0, 5'd0);
    read_check("t4_pend_kept", 32'h4, 32'h08);

    // 5: edge cases
    ack_pulse();
    tick();
    read_check("t5_idle_ack_pend", 32'h4, 32'h08);
    read_check("t5_idle_ack_infl", 32'h8, 32'h00);
    check_req("t5_idle_ack", 1'b0, 5'd0);
    bus_write(32'h0, 32'hFFFF_FF08);
    read_check("t5_enable_upper", 32'h0, 32'h08);
    tick();
    check_req("t5_req3", 1'b1, 5'd3);
    ack_pulse();
    bus_write(32'hC, 32'd9);
    bus_write(32'hC, 32'd11);
    bus_write(32'hC, 32'd2);
    read_check("t5_bad_complete", 32'h8, 32'h08);
    bus_write(32'h4, 32'hFF);
    bus_write(32'h8, 32'h00);
    read_check("t5_ro_pend", 32'h4, 32'h00);
    read_check("t5_ro_infl", 32'h8, 32'h08);
    read_check("t5_read_c", 32'hC, 32'h0);
    read_check("t5_read_7", 32'h7, 32'h0);
    bus_write(32'hC, 32'd3);
    read_check("t5_complete3", 32'h8, 32'h00);

    // 6: reset while in REQ with INFLIGHT=0x04
    bus_write(32'h0, 32'hFF);
    int_src_i = 8'h04;
    tick();
    tick();
    check_req("t6_req2", 1'b1, 5'd2);
    int_src_i = 8'h00;
    ack_pulse();
    int_src_i = 8'h01;
    tick();
    tick();
    check_req("t6_req0", 1'b1, 5'd0);
    read_check("t6_inflight", 32'h8, 32'h04);
    int_src_i = 8'h00;
    rst = 1'b1;
    read_check("t6_data_o_rst", 32'h8, 32'h0);
    tick();
    check("t6_rst_data_o", data_o, 32'h0);
    check_req("t6_rst", 1'b0, 5'd0);
    check("t6_rst_id", {27'b0, int_id_o}, 32'h0);
    rst = 1'b0;
    read_check("t6_enable", 32'h0, 32'h0);
    read_check("t6_pending", 32'h4, 32'h0);
    read_check("t6_inflight0", 32'h8, 32'h0);
    tick();
    tick();
    check_req("t6_quiet", 1'b0, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
